rmc_enable_debounce: RTL and testbench
======================================

// Module: rmc_enable_debounce
// PURPOSE
//  Qualifies the raw RMC_enable pin before the RMC enable delay/control stage.
//  - Synchronises the async pin into clk_in.
//  - Filters glitches with independent rise/fall qualification times, counted in iTick strobes.
//  - Drives oRMC_enable_debounce, which is the debounced-enable input of the downstream enable-control stage.
//  - Reports edge pulses and a saturating glitch count for CPLD register readback.
// PARAMETERS
//  SYNC_STAGES  2       synchroniser depth; legal values are 2 or 3
//  RISE_CNT     16'd4   ticks the input must stay high to qualify a rise; 0 is treated as 1
//  FALL_CNT     16'd8   ticks the input must stay low to qualify a fall; 0 is treated as 1
//  RST_VALUE    1'b1    output level and initial state after reset (enable asserted)
// PORTS
//  clk_in                 in   1   system clock
//  iRst_n                 in   1   asynchronous, active-low reset
//  iTick                  in   1   1-clk qualification strobe (e.g. 1 ms) from the shared timebase
//  iClear                 in   1   sync clear of oGlitch_cnt; level-sensitive
//  iRMC_enable_raw        in   1   raw asynchronous pin level
//  oRMC_enable_debounce   out  1   qualified level
//  oRise_pulse            out  1   1-clk pulse when a rise is qualified
//  oFall_pulse            out  1   1-clk pulse when a fall is qualified
//  oGlitch_cnt            out  8   count of aborted qualifications; saturates at 8'hFF
// BEHAVIOUR
//  Reset values:
//   - Synchroniser flops = RST_VALUE; oRMC_enable_debounce = RST_VALUE.
//   - Pulses = 0; oGlitch_cnt = 0; qualification counter = 0.
//   - State = ST_HI if RST_VALUE is 1, else ST_LO.
//  Synchroniser: SYNC_STAGES flops; s_in = last stage. Pin-to-s_in latency = SYNC_STAGES clks.
//  FSM states: ST_HI, ST_QLO, ST_LO, ST_QHI. The counter is 16 bit and is cleared on every state entry.
//   ST_HI : s_in==0 -> ST_QLO. Output stays 1.
//   ST_QLO: s_in==1 -> ST_HI and glitch event.
//           Else, on iTick: if cnt==FALL_CNT-1 -> ST_LO, output<=0, oFall_pulse=1;
//           otherwise cnt<=cnt+1.
//   ST_LO : s_in==1 -> ST_QHI. Output stays 0.
//   ST_QHI: mirror of ST_QLO using RISE_CNT. Qualification -> ST_HI, output<=1, oRise_pulse=1.
//           s_in==0 -> ST_LO and glitch event.
//  Timing rules:
//   - Output changes registered, in the same edge as the FSM transition into ST_HI/ST_LO.
//   - Qualification = exactly N iTick strobes observed in the Q state. The tick arriving in the entry cycle is not counted.
//  Simultaneous events:
//   - s_in reversal and iTick in the same clk: reversal wins; glitch counted, no qualification.
//   - iClear and glitch event in the same clk: clear wins; cnt=0.
//   - Glitch event when oGlitch_cnt==FF: holds at FF.
//  Counter: 16-bit compare against (N==0 ? 0 : N-1). The counter never wraps; it is bounded by the compare.
//  Pulses: asserted only for the transition clk; never both in one clk.
//  Reset mid-qualification: all state returns to the reset values; no pulse is emitted.
//  iTick held high continuously: counts one per clk. This is legal and is used in sim to shorten qualification.
// STRUCTURE
//  Package rmc_pkg:
//   - FSM state encoding (2 bits: ST_HI=2'b00, ST_QLO=2'b01, ST_LO=2'b10, ST_QHI=2'b11).
//   - CNT_W=16 and GLITCH_W=8 constants, shared with the RMC enable control stage.
//  Sub-module rmc_sync: parameterised SYNC_STAGES flop chain with reset value RST_VALUE. It is reused for the other RMC pins.
//  Top level holds the FSM, the qualification counter, the glitch counter and the pulse regs.
// TESTING (RISE_CNT=4, FALL_CNT=8, SYNC_STAGES=2, iTick every 10 clk)
//  1 Reset release, raw=1 held:
//    out=1, pulses 0, glitch 0 after reset; no change over 200 clk.
//  2 Raw 1->0 held:
//    oFall_pulse exactly once, on the 8th tick after s_in falls; out=0 the same edge; no earlier change.
//  3 Raw 0 for 3 ticks then back to 1:
//    out stays 1, oGlitch_cnt=1, no pulses.
//    Repeat 300 times -> oGlitch_cnt saturates at 8'hFF.
//  4 From out=0, raw 0->1 held:
//    oRise_pulse on the 4th tick; reversal in the same clk as the 4th tick -> no rise, glitch+1.
//  5 iClear asserted with a coincident glitch:
//    oGlitch_cnt=0 next clk; iRst_n pulsed low mid-ST_QLO -> out=1, cnt=0, no oFall_pulse.
//  6 RISE_CNT=0 build, iTick tied 1:
//    rise qualifies 1 clk after entering ST_QHI; the rise behaves as RISE_CNT=1.

Source files
------------

// File: rtl/rmc_pkg.sv
// Shared RMC definitions: FSM encoding, counter widths and
// the qualification-limit helper used by the RMC pin stages.
package rmc_pkg;

  localparam int CNT_W    = 16;
  localparam int GLITCH_W = 8;

  typedef enum logic [1:0] {
    ST_HI  = 2'b00,
    ST_QLO = 2'b01,
    ST_LO  = 2'b10,
    ST_QHI = 2'b11
  } rmc_st_e;

  // A zero tick count behaves like one tick.
  function automatic logic [CNT_W-1:0] qual_lim(
    input logic [CNT_W-1:0] n
  );
    return (n == '0) ? '0 : n - 16'd1;
  endfunction

endpackage

// File: rtl/rmc_sync.sv
// Reset-valued flop chain bringing an asynchronous RMC pin
// into clk_in; depth is SYNC_STAGES (2 or 3).
module rmc_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VALUE   = 1'b1
) (
  input  logic clk_in,
  input  logic iRst_n,
  input  logic d_in,
  output logic s_out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
  end

  always_ff @(posedge clk_in or negedge iRst_n) begin
    if (!iRst_n) begin
      sync_q <= {SYNC_STAGES{RST_VALUE}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign s_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rmc_enable_debounce.sv
// Debounces the raw RMC_enable pin with separate rise/fall
// tick qualification, edge pulses and a glitch counter.
module rmc_enable_debounce
  import rmc_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [15:0] RISE_CNT   = 16'd4,
  parameter logic [15:0] FALL_CNT   = 16'd8,
  parameter logic       RST_VALUE   = 1'b1
) (
  input  logic                clk_in,
  input  logic                iRst_n,
  input  logic                iTick,
  input  logic                iClear,
  input  logic                iRMC_enable_raw,
  output logic                oRMC_enable_debounce,
  output logic                oRise_pulse,
  output logic                oFall_pulse,
  output logic [GLITCH_W-1:0] oGlitch_cnt
);

  localparam logic [CNT_W-1:0] RISE_LIM = qual_lim(RISE_CNT);
  localparam logic [CNT_W-1:0] FALL_LIM = qual_lim(FALL_CNT);
  localparam rmc_st_e RST_ST = RST_VALUE ? ST_HI : ST_LO;

  logic s_in;

  rmc_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .RST_VALUE  (RST_VALUE)
  ) u_sync (
    .clk_in(clk_in),
    .iRst_n(iRst_n),
    .d_in  (iRMC_enable_raw),
    .s_out (s_in)
  );

  rmc_st_e             state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  logic                out_q, out_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;
  logic                glitch_ev;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    glitch_ev = 1'b0;
    unique case (state_q)
      ST_HI: begin
        if (!s_in) begin
          state_d = ST_QLO;
          cnt_d   = '0;
        end
      end
      ST_QLO: begin
        // A reversal beats a coincident tick.
        if (s_in) begin
          state_d   = ST_HI;
          cnt_d     = '0;
          glitch_ev = 1'b1;
        end else if (iTick) begin
          if (cnt_q == FALL_LIM) begin
            state_d = ST_LO;
            cnt_d   = '0;
            out_d   = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      ST_LO: begin
        if (s_in) begin
          state_d = ST_QHI;
          cnt_d   = '0;
        end
      end
      ST_QHI: begin
        if (!s_in) begin
          state_d   = ST_LO;
          cnt_d     = '0;
          glitch_ev = 1'b1;
        end else if (iTick) begin
          if (cnt_q == RISE_LIM) begin
            state_d = ST_HI;
            cnt_d   = '0;
            out_d   = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      default: begin
        state_d = RST_ST;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    glitch_d = glitch_q;
    if (iClear) begin
      glitch_d = '0;
    end else if (glitch_ev && (glitch_q != '1)) begin
      glitch_d = glitch_q + 8'd1;
    end
  end

  always_ff @(posedge clk_in or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q  <= RST_ST;
      cnt_q    <= '0;
      glitch_q <= '0;
      out_q    <= RST_VALUE;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      glitch_q <= glitch_d;
      out_q    <= out_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign oRMC_enable_debounce = out_q;
  assign oRise_pulse          = rise_q;
  assign oFall_pulse          = fall_q;
  assign oGlitch_cnt          = glitch_q;

endmodule

// File: tb/tb_rmc_enable_debounce.sv
// Bench for rmc_enable_debounce: vector table with scoreboard
// plus cycle-exact sequences for qualification corner cases.
module tb_rmc_enable_debounce;

  typedef struct {
    int   low;
    int   dg;
    int   r;
    int   f;
    logic out;
  } vec_t;

  typedef struct {
    int   g;
    int   r;
    int   f;
    logic out;
  } exp_t;

  logic       clk_in = 1'b0;
  logic       iRst_n = 1'b0;
  logic       iTick = 1'b0;
  logic       iClear = 1'b0;
  logic       raw = 1'b1;
  logic       raw1 = 1'b0;
  logic       out, rise, fall;
  logic [7:0] gcnt;
  logic       out1, rise1, fall1;
  logic [7:0] gcnt1;

  int   ncmp = 0;
  int   nfail = 0;
  int   nrise = 0;
  int   nfall = 0;
  int   nboth = 0;
  int   tph = 0;
  int   exp_g = 0;
  int   g0;
  vec_t vt[5];
  exp_t sb[$];
  exp_t e;

  always #5 clk_in = ~clk_in;

  rmc_enable_debounce u_dut (
    .clk_in              (clk_in),
    .iRst_n              (iRst_n),
    .iTick               (iTick),
    .iClear              (iClear),
    .iRMC_enable_raw     (raw),
    .oRMC_enable_debounce(out),
    .oRise_pulse         (rise),
    .oFall_pulse         (fall),
    .oGlitch_cnt         (gcnt)
  );

  rmc_enable_debounce #(
    .SYNC_STAGES(2),
    .RISE_CNT   (16'd0),
    .FALL_CNT   (16'd0),
    .RST_VALUE  (1'b0)
  ) u_z (
    .clk_in              (clk_in),
    .iRst_n              (iRst_n),
    .iTick               (1'b1),
    .iClear              (1'b0),
    .iRMC_enable_raw     (raw1),
    .oRMC_enable_debounce(out1),
    .oRise_pulse         (rise1),
    .oFall_pulse         (fall1),
    .oGlitch_cnt         (gcnt1)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] expv);
    ncmp++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s: got %0h, want %0h", name, act, expv);
    end
  endtask

  task automatic cyc(input logic t);
    iTick = t;
    @(posedge clk_in);
    #1;
    if (rise) nrise++;
    if (fall) nfall++;
    if (rise && fall) nboth++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(tph == 9);
      tph = (tph + 1) % 10;
    end
  endtask

  // Fall must land on the 8th counted tick; entry tick ignored.
  task automatic fall_seq(input string tag);
    nfall = 0;
    raw = 1'b0;
    cyc(0);
    cyc(0);
    cyc(1);
    for (int i = 0; i < 7; i++) begin
      cyc(1);
      cyc(0);
    end
    chk({tag, "_early_out"}, out, 1'b1);
    chk({tag, "_early_fall"}, nfall, 0);
    cyc(1);
    chk({tag, "_fall_pulse"}, fall, 1'b1);
    chk({tag, "_out_low"}, out, 1'b0);
    cyc(0);
    chk({tag, "_fall_once"}, nfall, 1);
    chk({tag, "_pulse_end"}, fall, 1'b0);
  endtask

  task automatic rise_seq(input string tag);
    nrise = 0;
    raw = 1'b1;
    cyc(0);
    cyc(0);
    cyc(1);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      cyc(0);
    end
  endtask

  initial begin
    vt[0] = '{low: 1,   dg: 1, r: 0, f: 0, out: 1'b1};
    vt[1] = '{low: 30,  dg: 1, r: 0, f: 0, out: 1'b1};
    vt[2] = '{low: 70,  dg: 1, r: 0, f: 0, out: 1'b1};
    vt[3] = '{low: 100, dg: 0, r: 1, f: 1, out: 1'b1};
    vt[4] = '{low: 2,   dg: 1, r: 0, f: 0, out: 1'b1};

    repeat (3) cyc(0);
    chk("rst_out", out, 1'b1);
    chk("rst_gl", gcnt, 8'h00);
    iRst_n = 1'b1;
    cyc(0);
    chk("rel_out", out, 1'b1);
    chk("rel_rise", rise, 1'b0);
    chk("rel_fall", fall, 1'b0);
    chk("rel_gl", gcnt, 8'h00);
    chk("rel_z_out", out1, 1'b0);
    run(200);
    chk("idle_out", out, 1'b1);
    chk("idle_pulses", nrise + nfall, 0);
    chk("idle_gl", gcnt, 8'h00);

    for (int v = 0; v < 5; v++) begin
      exp_g = exp_g + vt[v].dg;
      sb.push_back('{g: exp_g, r: vt[v].r, f: vt[v].f, out: vt[v].out});
      nrise = 0;
      nfall = 0;
      raw = 1'b0;
      run(vt[v].low);
      raw = 1'b1;
      run(80);
      e = sb.pop_front();
      chk($sformatf("vec%0d_gl", v), gcnt, e.g);
      chk($sformatf("vec%0d_rise", v), nrise, e.r);
      chk($sformatf("vec%0d_fall", v), nfall, e.f);
      chk($sformatf("vec%0d_out", v), out, e.out);
    end

    fall_seq("fseq");

    rise_seq("rrev");
    g0 = gcnt;
    raw = 1'b0;
    cyc(0);
    cyc(0);
    cyc(1);
    chk("rrev_out", out, 1'b0);
    chk("rrev_norise", nrise, 0);
    chk("rrev_gl", gcnt, g0 + 1);
    cyc(0);
    cyc(0);

    rise_seq("rise");
    chk("rise_early_out", out, 1'b0);
    chk("rise_early", nrise, 0);
    cyc(1);
    chk("rise_pulse", rise, 1'b1);
    chk("rise_out", out, 1'b1);
    cyc(0);
    chk("rise_pulse_end", rise, 1'b0);
    chk("rise_once", nrise, 1);

    raw = 1'b0;
    cyc(0);
    raw = 1'b1;
    cyc(0);
    iClear = 1'b1;
    cyc(0);
    cyc(0);
    chk("clr_coinc", gcnt, 8'h00);
    iClear = 1'b0;
    cyc(0);
    chk("clr_hold", gcnt, 8'h00);
    raw = 1'b0;
    cyc(0);
    raw = 1'b1;
    repeat (4) cyc(0);
    chk("clr_then_gl", gcnt, 8'h01);
    chk("clr_out", out, 1'b1);

    nfall = 0;
    raw = 1'b0;
    repeat (3) cyc(0);
    repeat (2) begin
      cyc(1);
      cyc(0);
    end
    iRst_n = 1'b0;
    #1;
    chk("mid_rst_out", out, 1'b1);
    chk("mid_rst_gl", gcnt, 8'h00);
    raw = 1'b1;
    repeat (2) cyc(0);
    iRst_n = 1'b1;
    repeat (4) cyc(0);
    chk("mid_rst_nofall", nfall, 0);
    chk("mid_rst_out2", out, 1'b1);
    fall_seq("post_rst");
    raw = 1'b1;
    run(80);
    chk("post_rst_back", out, 1'b1);

    nfall = 0;
    for (int i = 0; i < 300; i++) begin
      raw = 1'b0;
      cyc(0);
      raw = 1'b1;
      repeat (5) cyc(0);
    end
    chk("sat_gl", gcnt, 8'hFF);
    chk("sat_nofall", nfall, 0);
    raw = 1'b0;
    cyc(0);
    raw = 1'b1;
    repeat (5) cyc(0);
    chk("sat_hold", gcnt, 8'hFF);

    raw1 = 1'b1;
    repeat (3) cyc(0);
    chk("z_entry_out", out1, 1'b0);
    cyc(0);
    chk("z_rise_out", out1, 1'b1);
    chk("z_rise_pulse", rise1, 1'b1);
    cyc(0);
    chk("z_rise_end", rise1, 1'b0);
    raw1 = 1'b0;
    repeat (3) cyc(0);
    chk("z_fentry_out", out1, 1'b1);
    cyc(0);
    chk("z_fall_out", out1, 1'b0);
    chk("z_fall_pulse", fall1, 1'b1);
    chk("z_gl", gcnt1, 8'h00);

    chk("no_both_pulses", nboth, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
